// File: rtl/fwrisc_exec_mem_stim_if.sv
// Decode-side and data-bus signals between the fwrisc exec unit and its
// load/store stimulus generator / data-memory responder.
`timescale 1ns/1ps
interface fwrisc_exec_mem_stim_if;
  logic        decode_valid;
  logic        instr_complete;
  logic        instr_c;
  logic [4:0]  op_type;
  logic [5:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] op_c;
  logic [5:0]  rd;
  logic        dvalid;
  logic [31:0] daddr;
  logic        dwrite;
  logic [31:0] dwdata;
  logic [3:0]  dwstb;
  logic [31:0] drdata;
  logic        dready;

  // Stimulus/memory side: drives instructions, answers data requests.
  modport master (
    output decode_valid, instr_c, op_type, op, op_a, op_b, op_c, rd, drdata, dready,
    input  instr_complete, dvalid, daddr, dwrite, dwdata, dwstb
  );

  // Exec side: consumes instructions, issues data requests.
  modport slave (
    input  decode_valid, instr_c, op_type, op, op_a, op_b, op_c, rd, drdata, dready,
    output instr_complete, dvalid, daddr, dwrite, dwdata, dwstb
  );
endinterface

// File: rtl/fwrisc_exec_mem_stim.sv
// Load/store instruction generator plus latency-programmable byte-writable
// data memory for the fwrisc exec unit, with sticky fault flags.
`timescale 1ns/1ps
module fwrisc_exec_mem_stim #(
  parameter int         DATA_LAT       = 1,
  parameter int         MEM_WORDS      = 16,
  parameter int         ALLOW_MISALIGN = 0,
  parameter int         ISSUE_GAP      = 0,
  parameter int         NUM_INSTR      = 0,
  parameter int         TIMEOUT        = 64,
  parameter logic [4:0] OP_TYPE_LDST   = 5'd2
) (
  input  logic                           clock,
  input  logic                           reset,
  fwrisc_exec_mem_stim_if.master         bus,
  input  logic [3:0]                     stim_op,
  input  logic [31:0]                    stim_base,
  input  logic [7:0]                     stim_off,
  input  logic [31:0]                    stim_data,
  input  logic [4:0]                     stim_rd,
  output logic [15:0]                    instr_count,
  output logic                           done,
  output logic                           err_align,
  output logic                           err_proto,
  output logic                           err_timeout
);
  localparam int          AW       = $clog2(MEM_WORDS);
  localparam logic [15:0] TMO      = 16'(TIMEOUT);
  localparam logic [15:0] NI       = 16'(NUM_INSTR);
  localparam logic [15:0] GAP_LAST = 16'(ISSUE_GAP - 1);
  localparam logic [3:0]  LAT_LAST = 4'(DATA_LAT - 2);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} issue_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_RESP, R_REC} resp_state_t;

  // Legal strobe patterns and the address low bits each one requires.
  function automatic logic misaligned(input logic [1:0] a, input logic [3:0] s);
    case (s)
      4'b0001: misaligned = (a != 2'b00);
      4'b0010: misaligned = (a != 2'b01);
      4'b0100: misaligned = (a != 2'b10);
      4'b1000: misaligned = (a != 2'b11);
      4'b0011: misaligned = (a != 2'b00);
      4'b1100: misaligned = (a != 2'b10);
      4'b1111: misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  issue_state_t state_q, state_d;
  logic         valid_q, valid_d;
  logic [2:0]   op_q, op_d;
  logic [31:0]  op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
  logic [4:0]   rd_q, rd_d;
  logic [15:0]  count_q, count_d, gap_q, gap_d, tmo_q, tmo_d;
  logic         err_timeout_q, err_timeout_d;

  resp_state_t  r_state_q, r_state_d;
  logic [3:0]   lat_q, lat_d;
  logic [31:0]  addr_q, addr_d, wdata_q, wdata_d, drdata_q, drdata_d;
  logic         wr_q, wr_d;
  logic [3:0]   stb_q, stb_d;
  logic         err_align_q, err_align_d, err_proto_q, err_proto_d;
  logic [31:0]  mem_q [MEM_WORDS];
  logic [31:0]  mem_d [MEM_WORDS];
  logic         proto_bad_s;
  logic         stim_op_unused;

  assign stim_op_unused = stim_op[3];

  // Issue FSM next-state and operand formation.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    op_d          = op_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_c_d        = op_c_q;
    rd_d          = rd_q;
    count_d       = count_q;
    gap_d         = gap_q;
    tmo_d         = tmo_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      S_IDLE: state_d = S_ISSUE;
      S_ISSUE: begin
        op_d    = stim_op[2:0];
        op_b_d  = stim_data;
        rd_d    = stim_rd;
        valid_d = 1'b1;
        tmo_d   = 16'd0;
        state_d = S_WAIT;
        case (stim_op[2:0])
          3'd0, 3'd3, 3'd5: begin
            op_a_d = stim_base;
            op_c_d = {{24{stim_off[7]}}, stim_off};
          end
          3'd1, 3'd4, 3'd6: begin
            op_a_d = {stim_base[31:1], (ALLOW_MISALIGN != 0) ? stim_base[0] : 1'b0};
            op_c_d = {{23{stim_off[7]}}, stim_off, 1'b0};
          end
          default: begin
            op_a_d = {stim_base[31:2], (ALLOW_MISALIGN != 0) ? stim_base[1:0] : 2'b00};
            op_c_d = {{22{stim_off[7]}}, stim_off, 2'b00};
          end
        endcase
      end
      S_WAIT: begin
        if (bus.instr_complete) begin
          valid_d = 1'b0;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          gap_d   = 16'd0;
          if ((NUM_INSTR != 0) && (count_d == NI)) begin
            state_d = S_DONE;
          end else if (ISSUE_GAP > 0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tmo_d = (tmo_q == TMO) ? tmo_q : tmo_q + 16'd1;
          if (tmo_d == TMO) begin
            err_timeout_d = 1'b1;
          end else begin
            err_timeout_d = err_timeout_q;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Responder next-state, request capture and fault detection.
  always_comb begin
    r_state_d   = r_state_q;
    lat_d       = lat_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    stb_d       = stb_q;
    drdata_d    = drdata_q;
    err_align_d = err_align_q;
    err_proto_d = err_proto_q;
    proto_bad_s = !bus.dvalid || (bus.daddr != addr_q) || (bus.dwrite != wr_q) ||
                  (bus.dwdata != wdata_q) || (bus.dwstb != stb_q);
    case (r_state_q)
      R_IDLE: begin
        if (bus.dvalid) begin
          addr_d    = bus.daddr;
          wr_d      = bus.dwrite;
          wdata_d   = bus.dwdata;
          stb_d     = bus.dwstb;
          lat_d     = 4'd0;
          r_state_d = (DATA_LAT <= 1) ? R_RESP : R_LAT;
          if ((ALLOW_MISALIGN == 0) && misaligned(bus.daddr[1:0], bus.dwstb)) begin
            err_align_d = 1'b1;
          end else begin
            err_align_d = err_align_q;
          end
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_LAT: begin
        if (lat_q == LAT_LAST) begin
          r_state_d = R_RESP;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      R_RESP:  r_state_d = R_REC;
      R_REC:   r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    if (((r_state_q == R_LAT) || (r_state_q == R_RESP)) && proto_bad_s) begin
      err_proto_d = 1'b1;
    end else begin
      err_proto_d = err_proto_q;
    end
    // Read data is loaded on entry to R_RESP; stores leave drdata untouched.
    if ((r_state_d == R_RESP) && (r_state_q != R_RESP) && !wr_d) begin
      drdata_d = mem_q[addr_d[AW+1:2]];
    end else begin
      drdata_d = drdata_q;
    end
  end

  // Byte-lane store update, committed at the R_RESP edge.
  always_comb begin
    mem_d = mem_q;
    if ((r_state_q == R_RESP) && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (stb_q[b]) begin
          mem_d[addr_q[AW+1:2]][8*b +: 8] = wdata_q[8*b +: 8];
        end else begin
          mem_d[addr_q[AW+1:2]][8*b +: 8] = mem_q[addr_q[AW+1:2]][8*b +: 8];
        end
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // Issue-side state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      valid_q       <= 1'b0;
      op_q          <= 3'd0;
      op_a_q        <= 32'd0;
      op_b_q        <= 32'd0;
      op_c_q        <= 32'd0;
      rd_q          <= 5'd0;
      count_q       <= 16'd0;
      gap_q         <= 16'd0;
      tmo_q         <= 16'd0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      op_q          <= op_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_c_q        <= op_c_d;
      rd_q          <= rd_d;
      count_q       <= count_d;
      gap_q         <= gap_d;
      tmo_q         <= tmo_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Responder state and memory registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q   <= R_IDLE;
      lat_q       <= 4'd0;
      addr_q      <= 32'd0;
      wr_q        <= 1'b0;
      wdata_q     <= 32'd0;
      stb_q       <= 4'd0;
      drdata_q    <= 32'd0;
      err_align_q <= 1'b0;
      err_proto_q <= 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      r_state_q   <= r_state_d;
      lat_q       <= lat_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      stb_q       <= stb_d;
      drdata_q    <= drdata_d;
      err_align_q <= err_align_d;
      err_proto_q <= err_proto_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.decode_valid = valid_q && !bus.instr_complete;
  assign bus.instr_c      = 1'b0;
  assign bus.op_type      = OP_TYPE_LDST;
  assign bus.op           = {3'b000, op_q};
  assign bus.op_a         = op_a_q;
  assign bus.op_b         = op_b_q;
  assign bus.op_c         = op_c_q;
  assign bus.rd           = {1'b0, rd_q};
  assign bus.drdata       = drdata_q;
  assign bus.dready       = (r_state_q == R_RESP);
  assign instr_count      = count_q;
  assign done             = (state_q == S_DONE);
  assign err_align        = err_align_q;
  assign err_proto        = err_proto_q;
  assign err_timeout      = err_timeout_q;
endmodule

// File: tb/tb_fwrisc_exec_mem_stim.sv
// Scoreboard bench: plays the exec unit against two configurations of the
// stimulus/memory block and checks decode and data responses against a model.
`timescale 1ns/1ps
module tb_fwrisc_exec_mem_stim;
  localparam int         LAT_A = 3;
  localparam int         LAT_B = 1;
  localparam int         GAP_B = 2;
  localparam int         NUM_B = 3;
  localparam int         TMO   = 64;
  localparam logic [4:0] LDST  = 5'd2;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [4:0]  rd;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sel = 1'b0;
  logic [3:0]  stim_op = 4'd0;
  logic [31:0] stim_base = 32'd0, stim_data = 32'd0;
  logic [7:0]  stim_off = 8'd0;
  logic [4:0]  stim_rd = 5'd0;
  logic        dvalid = 1'b0, dwrite = 1'b0, icpl = 1'b0;
  logic [31:0] daddr = 32'd0, dwdata = 32'd0;
  logic [3:0]  dwstb = 4'd0;

  fwrisc_exec_mem_stim_if ifa ();
  fwrisc_exec_mem_stim_if ifb ();

  assign ifa.instr_complete = icpl & ~sel;
  assign ifb.instr_complete = icpl & sel;
  assign ifa.dvalid = dvalid & ~sel;
  assign ifb.dvalid = dvalid & sel;
  assign ifa.daddr  = daddr;
  assign ifb.daddr  = daddr;
  assign ifa.dwrite = dwrite;
  assign ifb.dwrite = dwrite;
  assign ifa.dwdata = dwdata;
  assign ifb.dwdata = dwdata;
  assign ifa.dwstb  = dwstb;
  assign ifb.dwstb  = dwstb;

  logic [15:0] cnt_a, cnt_b;
  logic        done_a, done_b, ea_a, ea_b, ep_a, ep_b, et_a, et_b;

  fwrisc_exec_mem_stim #(.DATA_LAT(LAT_A), .MEM_WORDS(16), .ALLOW_MISALIGN(0),
                         .ISSUE_GAP(0), .NUM_INSTR(0), .TIMEOUT(TMO)) u_a (
    .clock(clk), .reset(rst_n), .bus(ifa),
    .stim_op(stim_op), .stim_base(stim_base), .stim_off(stim_off),
    .stim_data(stim_data), .stim_rd(stim_rd),
    .instr_count(cnt_a), .done(done_a), .err_align(ea_a), .err_proto(ep_a),
    .err_timeout(et_a));

  fwrisc_exec_mem_stim #(.DATA_LAT(LAT_B), .MEM_WORDS(16), .ALLOW_MISALIGN(0),
                         .ISSUE_GAP(GAP_B), .NUM_INSTR(NUM_B), .TIMEOUT(TMO)) u_b (
    .clock(clk), .reset(rst_n), .bus(ifb),
    .stim_op(stim_op), .stim_base(stim_base), .stim_off(stim_off),
    .stim_data(stim_data), .stim_rd(stim_rd),
    .instr_count(cnt_b), .done(done_b), .err_align(ea_b), .err_proto(ep_b),
    .err_timeout(et_b));

  wire        m_dv   = sel ? ifb.decode_valid : ifa.decode_valid;
  wire        m_ic   = sel ? ifb.instr_c : ifa.instr_c;
  wire [4:0]  m_opt  = sel ? ifb.op_type : ifa.op_type;
  wire [5:0]  m_op   = sel ? ifb.op : ifa.op;
  wire [31:0] m_a    = sel ? ifb.op_a : ifa.op_a;
  wire [31:0] m_b    = sel ? ifb.op_b : ifa.op_b;
  wire [31:0] m_c    = sel ? ifb.op_c : ifa.op_c;
  wire [5:0]  m_rdst = sel ? ifb.rd : ifa.rd;
  wire [31:0] m_rd   = sel ? ifb.drdata : ifa.drdata;
  wire        m_rdy  = sel ? ifb.dready : ifa.dready;
  wire [15:0] m_cnt  = sel ? cnt_b : cnt_a;
  wire        m_done = sel ? done_b : done_a;
  wire        m_ea   = sel ? ea_b : ea_a;
  wire        m_ep   = sel ? ep_b : ep_a;
  wire        m_et   = sel ? et_b : et_a;

  int vec = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vec++;
    bad++;
    $display("FAIL %s: expected event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Reference model state: memory image, last presented read word, scoreboards.
  logic [31:0] mem_m [16];
  logic [31:0] last_rd;
  dec_t        dec_q [$];
  logic [31:0] resp_q [$];
  int          dv_cyc = 0, cpl_cyc = 0, done_cnt = 0, rises_b = 0;
  bit          have_cpl = 1'b0;
  int          size_of [8] = '{1, 2, 4, 1, 2, 1, 2, 4};

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
    last_rd  = 32'd0;
    have_cpl = 1'b0;
    done_cnt = 0;
    dec_q.delete();
    resp_q.delete();
  endtask

  // Monitor: compares each newly presented instruction and each data response.
  logic prev_dv = 1'b0, prev_rdy = 1'b0;
  always @(negedge clk) begin
    dec_t d;
    logic [31:0] r;
    if (m_dv && !prev_dv) begin
      if (sel) rises_b <= rises_b + 1;
      if (dec_q.size() == 0) begin
        fail_now("decode_unexpected");
      end else begin
        d = dec_q.pop_front();
        check("op", 32'(m_op), 32'({3'b000, d.op}));
        check("op_a", m_a, d.a);
        check("op_b", m_b, d.b);
        check("op_c", m_c, d.c);
        check("rd", 32'(m_rdst), 32'({1'b0, d.rd}));
        check("instr_c", 32'(m_ic), 32'd0);
        check("op_type", 32'(m_opt), 32'(LDST));
      end
    end
    if (m_rdy) begin
      check("dready_one_cycle", 32'(prev_rdy), 32'd0);
      if (resp_q.size() == 0) begin
        fail_now("dready_unexpected");
      end else begin
        r = resp_q.pop_front();
        check("drdata", m_rd, r);
        check("dready_latency", 32'(cyc - dv_cyc), 32'(sel ? LAT_B : LAT_A));
      end
    end
    prev_dv  <= m_dv;
    prev_rdy <= m_rdy;
  end

  // mode: 0 normal, 1 request address off by one, 2 drop dvalid mid-latency,
  // 3 withhold instr_complete past the timeout.
  task automatic run_instr(input logic [3:0] op, input logic [31:0] base, input logic [7:0] off,
                           input logic [31:0] data, input logic [4:0] rd, input int mode);
    logic [2:0]  o;
    int          sz, so, n;
    bit          st;
    logic [31:0] a, c, addr, wd;
    logic [3:0]  stb;
    logic [3:0]  idx;
    dec_t        d;
    o  = op[2:0];
    sz = size_of[o];
    st = (o >= 3'd5);
    so = $signed(off);
    a  = base & ~(32'(sz) - 32'd1);
    c  = 32'(so * sz);
    stim_op = op; stim_base = base; stim_off = off; stim_data = data; stim_rd = rd;
    d.op = o; d.a = a; d.b = data; d.c = c; d.rd = rd;
    dec_q.push_back(d);
    addr = a + c;
    stb  = (sz == 1) ? (4'b0001 << addr[1:0]) : (sz == 2) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd   = (sz == 1) ? {4{data[7:0]}} : (sz == 2) ? {2{data[15:0]}} : data;
    if (mode == 1) addr = addr - 32'd1;
    idx = addr[5:2];
    if (st) begin
      resp_q.push_back(last_rd);
      for (int l = 0; l < 4; l++) if (stb[l]) mem_m[idx][8*l +: 8] = wd[8*l +: 8];
    end else begin
      last_rd = mem_m[idx];
      resp_q.push_back(last_rd);
    end

    @(negedge clk);
    n = 0;
    while (!m_dv && n < 100) begin @(negedge clk); n++; end
    if (!m_dv) fail_now("issue_wait");
    // Complete in cycle c -> idle states -> ISSUE -> decode_valid visible.
    if (have_cpl) check("reissue_gap", 32'(cyc - cpl_cyc), 32'((sel ? GAP_B : 0) + 3));

    @(posedge clk); #1;
    dvalid = 1'b1; daddr = addr; dwrite = st; dwdata = wd; dwstb = stb; dv_cyc = cyc;
    if (mode == 2) begin @(posedge clk); #1; dvalid = 1'b0; end
    @(negedge clk);
    n = 0;
    while (!m_rdy && n < 50) begin @(negedge clk); n++; end
    if (!m_rdy) fail_now("dready_wait");
    @(posedge clk); #1;
    dvalid = 1'b0;
    if (mode == 3) begin
      repeat (5) @(negedge clk);
      check("err_timeout_early", 32'(m_et), 32'd0);
      repeat (TMO + 5) @(negedge clk);
      check("err_timeout", 32'(m_et), 32'd1);
      @(posedge clk); #1;
    end
    icpl = 1'b1; cpl_cyc = cyc; have_cpl = 1'b1;
    @(posedge clk); #1;
    icpl = 1'b0;
    done_cnt++;
  endtask

  task automatic check_reset();
    check("rst_decode_valid", 32'(m_dv), 32'd0);
    check("rst_op", 32'(m_op), 32'd0);
    check("rst_op_a", m_a, 32'd0);
    check("rst_op_b", m_b, 32'd0);
    check("rst_op_c", m_c, 32'd0);
    check("rst_rd", 32'(m_rdst), 32'd0);
    check("rst_op_type", 32'(m_opt), 32'(LDST));
    check("rst_drdata", m_rd, 32'd0);
    check("rst_dready", 32'(m_rdy), 32'd0);
    check("rst_count", 32'(m_cnt), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_errs", 32'({m_ea, m_ep, m_et}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Word store/load, byte store into the same word, byte load back.
    run_instr(4'd7, 32'h0000_0100, 8'h00, 32'hDEAD_BEEF, 5'd1, 0);
    run_instr(4'hA, 32'h0000_0100, 8'h00, 32'h0, 5'd2, 0);
    run_instr(4'd5, 32'h0000_0101, 8'h00, 32'h0000_00AA, 5'd3, 0);
    run_instr(4'd3, 32'h0000_0101, 8'h00, 32'h0, 5'd4, 0);
    check("mem_word_after_sb", mem_m[0], 32'hDEAD_AAEF);

    for (int i = 0; i < 40; i++) begin
      run_instr(4'($urandom_range(0, 15)), $urandom, 8'($urandom_range(0, 255)),
                $urandom, 5'($urandom_range(0, 31)), 0);
    end
    check("no_err_align", 32'(m_ea), 32'd0);
    check("no_err_proto", 32'(m_ep), 32'd0);
    check("no_err_timeout", 32'(m_et), 32'd0);

    run_instr(4'd1, 32'h0000_0203, 8'h00, 32'h0, 5'd5, 1);
    check("err_align_set", 32'(m_ea), 32'd1);
    check("err_proto_clear", 32'(m_ep), 32'd0);
    run_instr(4'd2, 32'h0000_0040, 8'h01, 32'h0, 5'd6, 2);
    check("err_proto_set", 32'(m_ep), 32'd1);
    check("err_align_sticky", 32'(m_ea), 32'd1);
    run_instr(4'd6, 32'h0000_0010, 8'hFF, 32'h1234_5678, 5'd7, 3);
    check("count_a", 32'(m_cnt), 32'(done_cnt));
    check("done_a_low", 32'(m_done), 32'd0);

    // Second configuration: single-cycle latency, gapped, bounded run.
    @(posedge clk); #1;
    rst_n = 1'b0;
    sel = 1'b1;
    model_reset();
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(4'd7, 32'h0000_0100, 8'h00, 32'hDEAD_BEEF, 5'd8, 0);
    run_instr(4'd2, 32'h0000_0100, 8'h00, 32'h0, 5'd9, 0);
    run_instr(4'd5, 32'h0000_0101, 8'h00, 32'h0000_00AA, 5'd10, 0);
    repeat (20) @(negedge clk);
    check("done_b", 32'(m_done), 32'd1);
    check("count_b", 32'(m_cnt), 32'(NUM_B));
    check("issues_b", 32'(rises_b), 32'(NUM_B));
    check("mem_b_after_sb", mem_m[0], 32'hDEAD_AAEF);

    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset();
    check("scoreboard_empty", 32'(dec_q.size() + resp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
